// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory port sequencer: turns level read/write requests into one-cycle strobes, waits for ack.
// Optional WAIT-state timeout with a sticky error flag is enabled by `define MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 i_or_d,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic [WORD_SIZE-1:0] write_data,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [WORD_SIZE-1:0] inst_data,
    output logic [WORD_SIZE-1:0] load_data,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_err,
    output logic [2:0]           o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WORD_SIZE-1:0]  r_mem_addr;
    logic [WORD_SIZE-1:0]  r_mem_wdata;
    logic [WORD_SIZE-1:0]  r_inst_data;
    logic [WORD_SIZE-1:0]  r_load_data;
    logic                  r_is_write;
    logic                  r_is_data;
    logic                  w_req;
    logic                  w_in_access;
    logic                  w_ack_rd;
    logic                  w_timeout;

    assign w_req       = mem_read | mem_write;
    assign w_in_access = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_ack_rd    = w_in_access && mem_ack && !r_is_write;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_err;

    // The last allowed WAIT cycle is the TIMEOUT_CYCLES-th; an ack there still wins.
    assign w_timeout = (r_state == S_WAIT) && !mem_ack &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)
                r_wait_cnt <= '0;
            else if (r_state == S_WAIT && !mem_ack)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout)
                r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req)
                    w_next = S_ISSUE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                mem_rd_en = !r_is_write;
                mem_wr_en = r_is_write;
                w_next    = mem_ack ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (mem_ack || w_timeout)
                    w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = w_req ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                // A request level still held from the finished access must not start another one.
                if (!w_req)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_inst_data <= '0;
            r_load_data <= '0;
            r_is_write  <= 1'b0;
            r_is_data   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req) begin
                r_mem_addr  <= i_or_d ? alu_out : pc;
                r_mem_wdata <= write_data;
                r_is_write  <= !mem_read;
                r_is_data   <= i_or_d;
            end
            if (w_ack_rd) begin
                if (r_is_data)
                    r_load_data <= mem_rdata;
                else
                    r_inst_data <= mem_rdata;
            end
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign inst_data   = r_inst_data;
    assign load_data   = r_load_data;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int W = 16;
`ifdef MEM_TIMEOUT_EN
  localparam int TO   = 4;
  localparam int KMAX = 3;
`else
  localparam int TO   = 16;
  localparam int KMAX = 5;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         mem_read = 1'b0, mem_write = 1'b0, i_or_d = 1'b0, mem_ack = 1'b0;
  logic [W-1:0] pc = '0, alu_out = '0, write_data = '0, mem_rdata = '0;
  logic [W-1:0] mem_addr, mem_wdata, inst_data, load_data;
  logic         mem_rd_en, mem_wr_en, busy, done, mem_err;
  logic [2:0]   dbg_state;

  mem_access_ctrl #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .pc(pc), .alu_out(alu_out), .write_data(write_data), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .inst_data(inst_data), .load_data(load_data), .busy(busy), .done(done), .mem_err(mem_err),
    .o_dbg_state(dbg_state)
  );

  // scoreboard
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_inst = '0;
  logic [W-1:0] model_load = '0;
  logic         exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_data(input string tag);
    check_eq({tag, "_inst"}, inst_data, model_inst);
    check_eq({tag, "_load"}, load_data, model_load);
    check_eq({tag, "_err"}, mem_err, exp_err);
  endtask

  // driver: one access with k WAIT cycles, request held for `hold` cycles after done
  task automatic do_access(input bit rd, input bit wr, input bit iod, input logic [W-1:0] pcv,
                           input logic [W-1:0] aluv, input logic [W-1:0] wdv,
                           input logic [W-1:0] rdv, input int k, input int hold);
    logic [W-1:0] exp_addr;
    logic [W-1:0] e;
    bit           is_wr;
    @(negedge clk);
    mem_read = rd; mem_write = wr; i_or_d = iod;
    pc = pcv; alu_out = aluv; write_data = wdv; mem_ack = 1'b0;
    exp_addr = iod ? aluv : pcv;
    is_wr = wr && !rd;
    if (!is_wr) exp_q.push_back(rdv);
    @(negedge clk);
    check_eq("issue_rd_en", mem_rd_en, !is_wr);
    check_eq("issue_wr_en", mem_wr_en, is_wr);
    check_eq("issue_addr", mem_addr, exp_addr);
    check_eq("issue_wdata", mem_wdata, wdv);
    check_eq("issue_busy", busy, 1'b1);
    check_eq("issue_done", done, 1'b0);
    check_data("issue");
    pc = W'($urandom); alu_out = W'($urandom); write_data = W'($urandom); i_or_d = 1'($urandom);
    if (k == 0) begin mem_ack = 1'b1; mem_rdata = rdv; end
    for (int w = 1; w <= k; w++) begin
      @(negedge clk);
      check_eq("wait_rd_en", mem_rd_en, 1'b0);
      check_eq("wait_wr_en", mem_wr_en, 1'b0);
      check_eq("wait_busy", busy, 1'b1);
      check_eq("wait_done", done, 1'b0);
      check_eq("wait_addr", mem_addr, exp_addr);
      if (w == k) begin mem_ack = 1'b1; mem_rdata = rdv; end
      else mem_rdata = W'($urandom);
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = W'($urandom);
    check_eq("done_pulse", done, 1'b1);
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_rd_en", mem_rd_en, 1'b0);
    check_eq("done_wr_en", mem_wr_en, 1'b0);
    if (!is_wr) begin
      e = exp_q.pop_front();
      if (iod) model_load = e; else model_inst = e;
    end
    check_data("done");
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_done", done, 1'b0);
      check_eq("hold_rd_en", mem_rd_en, 1'b0);
      check_eq("hold_wr_en", mem_wr_en, 1'b0);
      check_eq("hold_busy", busy, 1'b0);
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = W'($urandom);
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_wdata"}, mem_wdata, 0);
    check_eq({tag, "_strobes"}, {mem_rd_en, mem_wr_en}, 0);
    check_eq({tag, "_busy_done"}, {busy, done}, 0);
    check_eq({tag, "_inst"}, inst_data, 0);
    check_eq({tag, "_load"}, load_data, 0);
    check_eq({tag, "_err"}, mem_err, 0);
  endtask

  task automatic do_reset_mid_wait();
    @(negedge clk);
    mem_read = 1'b1; i_or_d = 1'b1; alu_out = W'($urandom); mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    reset = 1'b0; mem_read = 1'b0; mem_ack = 1'b1; mem_rdata = W'($urandom);
    @(negedge clk);
    mem_ack = 1'b0;
    model_inst = '0; model_load = '0; exp_err = 1'b0; exp_q.delete();
    check_all_zero("rst_late_ack");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic do_timeout();
    @(negedge clk);
    mem_read = 1'b1; i_or_d = 1'($urandom); pc = W'($urandom); alu_out = W'($urandom);
    mem_ack = 1'b0;
    @(negedge clk);
    check_eq("to_issue_rd_en", mem_rd_en, 1'b1);
    for (int w = 1; w <= TO; w++) begin
      @(negedge clk);
      check_eq("to_wait_busy", busy, 1'b1);
      check_eq("to_wait_done", done, 1'b0);
    end
    @(negedge clk);
    exp_err = 1'b1;
    check_eq("to_done", done, 1'b1);
    check_data("to_done");
    mem_read = 1'b0;
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // directed: fetch, store with 3 waits, read+write collision, held read
    do_access(1, 0, 0, 16'h0010, 16'h0999, 16'h0000, 16'h6A05, 0, 0);
    do_access(0, 1, 1, 16'h0123, 16'h0040, 16'hBEEF, 16'h0000, 3, 0);
    do_access(1, 1, 1, 16'h0456, 16'h0022, 16'hAAAA, 16'h1234, 1, 0);
    do_access(1, 0, 0, 16'h0200, 16'h0000, 16'h0000, 16'h5A5A, 2, 6);
    do_access(1, 0, 1, 16'h0300, 16'h0310, 16'h0000, 16'hC3C3, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int op;
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, 1'($urandom), W'($urandom), W'($urandom), W'($urandom),
                W'($urandom), $urandom_range(0, KMAX), $urandom_range(0, 4));
    end

`ifdef MEM_TIMEOUT_EN
    do_timeout();
    do_access(1, 0, 1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1, 0);
`endif

    do_reset_mid_wait();
    do_access(1, 0, 0, 16'h0044, 16'h0000, 16'h0000, 16'h7E7E, 2, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
